branch_predict_unit: RTL

- Next-generation branch resolution block for the pipelined core.
- Resolves all six RV32I conditional branches in EX (adds BLTU/BGEU).
- Holds a parametrised branch history table (BHT) of saturating counters that supplies a taken/not-taken prediction to IF.
- Flags mispredictions and keeps saturating statistics counters for perf analysis.

---
 rtl/branch_predict_unit.sv | 75 +++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: resolves RV32I conditional branches in EX, predicts
// from a BHT of saturating counters in IF, and counts branches/mispredictions.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic              zero_flag,
  input  logic              lt_flag,
  input  logic              ltu_flag,
  output logic              take_branch,
  output logic              mispredict,
  output logic              illegal_branch,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE = 1;
  // Weakly-not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_MAX >> 1;
  localparam logic [STAT_W-1:0] STAT_ONE = 1;

  logic [CTR_BITS-1:0] bht_q [BHT_ENTRIES];
  logic [CTR_BITS-1:0] ex_ctr, ctr_d;
  logic [STAT_W-1:0]   branch_count_q, branch_count_d;
  logic [STAT_W-1:0]   mispredict_count_q, mispredict_count_d;
  logic [IDX_W-1:0]    if_idx, ex_idx;
  logic                br, raw_dir, resolve_en;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign if_pred_taken = rst_n & bht_q[if_idx][CTR_BITS-1];
  assign branch_count = branch_count_q;
  assign mispredict_count = mispredict_count_q;

  // funct3[0] inverts the base condition; funct3[2:1] selects zero/lt/ltu.
  always_comb begin
    br             = ex_valid && ex_branch;
    illegal_branch = br && (ex_funct3[2:1] == 2'b01);
    resolve_en     = br && !illegal_branch;
    raw_dir        = ex_funct3[2] ? (ex_funct3[1] ? ltu_flag : lt_flag) : zero_flag;
    take_branch    = resolve_en && (raw_dir ^ ex_funct3[0]);
    mispredict     = resolve_en && (take_branch != ex_pred_taken);
    ex_ctr         = bht_q[ex_idx];
    ctr_d          = take_branch ? ((ex_ctr == CTR_MAX) ? ex_ctr : ex_ctr + CTR_ONE)
                                 : ((ex_ctr == '0) ? ex_ctr : ex_ctr - CTR_ONE);
    branch_count_d     = (resolve_en && branch_count_q != '1) ? branch_count_q + STAT_ONE
                                                               : branch_count_q;
    mispredict_count_d = (mispredict && mispredict_count_q != '1) ? mispredict_count_q + STAT_ONE
                                                                  : mispredict_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_RST;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (resolve_en) bht_q[ex_idx] <= ctr_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end
endmodule
